// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// Multiplies use shift-add and divides use restoring division, one bit per cycle.
// MTHI/MTLO write HI/LO in a single cycle.
//
// Handshake: start is sampled only while the unit is idle (busy low).
//   - An iterative op raises busy the cycle after it is accepted.
//   - busy drops in the same cycle that done pulses high for one cycle.
//   - hi/lo/div_zero are valid from that done cycle onward.
//   - start while busy is dropped, not queued.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               bzero_q, bzero_d;
    logic               neg_res_q, neg_res_d;   // negate product / quotient
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic [2*WIDTH-1:0] acc_q, acc_d;           // product, or dividend/quotient in low half
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;           // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               is_iter, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Decode the incoming request into magnitudes and sign flags.
    always_comb begin
        is_iter   = (op[2] == 1'b0);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // One iteration step of each algorithm, plus the final sign correction.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
        div_shift = {rem_q, acc_q[WIDTH-1]};
        // rem < divisor keeps the true difference below 2^WIDTH, so bit WIDTH is a clean borrow.
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[WIDTH];
        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
    end

    // Next-state and next-register values for the IDLE/CALC/FIX sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        bzero_d   = bzero_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_iter) begin
                        state_d   = S_CALC;
                        cnt_d     = '0;
                        is_div_d  = op[1];
                        bzero_d   = op[1] && (b == '0);
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        opb_d     = op[1] ? b_mag : a_mag;
                        acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        rem_d     = '0;
                        dz_d      = 1'b0;
                        busy_d    = 1'b1;
                    end else if (op == OP_MTHI) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (op == OP_MTLO) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // A zero divisor leaves |a| in the remainder, so rem_fix restores a itself.
                    hi_d = rem_fix;
                    lo_d = bzero_q ? {WIDTH{1'b1}} : quo_fix;
                    dz_d = bzero_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            bzero_q   <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            rem_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            bzero_q   <= bzero_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: 32-bit instance plus an 8-bit instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_div_unit;
    localparam logic [2:0] MULTU = 3'b000;
    localparam logic [2:0] MULT  = 3'b001;
    localparam logic [2:0] DIVU  = 3'b010;
    localparam logic [2:0] DIV   = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;
    // Falling edges from the start edge to the done cycle, and busy cycles, for WIDTH=32.
    localparam int LAT  = 34;
    localparam int BUSY = 33;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8, dz8;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [64:0] exp_q[$];          // {div_zero, hi, lo}
    logic [31:0] m_hi, m_lo;
    logic        m_dz;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: native operators with the divide corner cases spelled out.
    task automatic push_exp(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        logic signed [63:0] sp;
        case (o)
            MULTU: begin
                {m_hi, m_lo} = {32'b0, av} * {32'b0, bv};
                m_dz = 1'b0;
            end
            MULT: begin
                sp = $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
                {m_hi, m_lo} = sp;
                m_dz = 1'b0;
            end
            DIVU, DIV: begin
                if (bv == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = av; m_dz = 1'b1;
                end else if (o == DIV && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0; m_dz = 1'b0;
                end else if (o == DIV) begin
                    m_lo = $signed(av) / $signed(bv); m_hi = $signed(av) % $signed(bv); m_dz = 1'b0;
                end else begin
                    m_lo = av / bv; m_hi = av % bv; m_dz = 1'b0;
                end
            end
            MTHI: m_hi = av;
            MTLO: m_lo = av;
            default: return;
        endcase
        exp_q.push_back({m_dz, m_hi, m_lo});
    endtask

    // ---------------- driver tasks ----------------
    // Call at a falling edge; the request is sampled at the next rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; op = o; a = av; b = bv;
        push_exp(o, av, bv);
    endtask

    task automatic wait_result(input string tag, input int n0, input int bc0,
                               input int exp_lat, input int exp_busy);
        int          n;
        int          bc;
        logic        seen;
        logic [64:0] e;
        n = n0; bc = bc0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (busy) bc++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, {64'b0, seen}, 65'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        chk({tag, "_result"}, {div_zero, hi, lo}, e);
        chk({tag, "_latency"}, 65'(n), 65'(exp_lat));
        chk({tag, "_busy_cycles"}, 65'(bc), 65'(exp_busy));
        chk({tag, "_busy_low_at_done"}, {64'b0, busy}, 65'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [64:0] e;
        logic [64:0] prev;
        int          bc;
        int          dn;
        int          n;
        logic        seen;

        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
        start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hilo", {div_zero, hi, lo}, 65'd0);
        chk("reset_ctrl", {63'b0, busy, done}, 65'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(MULTU, 32'd6, 32'd16);
        wait_result("multu_6x16", 0, 0, LAT, BUSY);
        @(negedge clk);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 0, 0, LAT, BUSY);
        // Issued in the done cycle: the unit is idle and must accept it.
        issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mult_neg1_sq", 0, 0, LAT, BUSY);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_m7_by_2", 0, 0, LAT, BUSY);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_overflow", 0, 0, LAT, BUSY);
        issue(DIV, 32'd100, 32'hFFFF_FFF9);
        wait_result("div_100_by_m7", 0, 0, LAT, BUSY);
        issue(DIVU, 32'd30, 32'd0);
        wait_result("divu_by_zero", 0, 0, LAT, BUSY);
        @(negedge clk);
        chk("div_zero_sticky", {64'b0, div_zero}, 65'd1);
        issue(MULTU, 32'd3, 32'd3);
        wait_result("multu_3x3", 0, 0, LAT, BUSY);
        issue(DIV, 32'hFFFF_FFF0, 32'd0);
        wait_result("div_neg_by_zero", 0, 0, LAT, BUSY);
        issue(MULT, 32'h0001_2345, 32'hFFFF_0000 + $urandom_range(1, 65535));
        wait_result("mult_mixed_sign", 0, 0, LAT, BUSY);

        // MTHI then MTLO back to back: one done each, busy never raised.
        @(negedge clk);
        issue(MTHI, 32'h0000_1234, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("mthi_done", {63'b0, done, busy}, 65'b10);
        e = exp_q.pop_front();
        chk("mthi_result", {div_zero, hi, lo}, e);
        issue(MTLO, 32'h0000_5678, 32'hDEAD_BEEF);
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_done", {63'b0, done, busy}, 65'b10);
        e = exp_q.pop_front();
        chk("mtlo_result", {div_zero, hi, lo}, e);
        @(negedge clk);
        chk("mt_done_ends", {63'b0, done, busy}, 65'd0);

        // Reserved op: nothing happens.
        issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b0;
        chk("reserved_no_done", {63'b0, done, busy}, 65'd0);
        chk("reserved_hold", {1'b0, hi, lo}, {1'b0, m_hi, m_lo});

        // Start during busy is ignored; hi/lo hold old values mid-calculation.
        @(negedge clk);
        prev = {m_dz, m_hi, m_lo};
        issue(MULTU, 32'd6, 32'd16);
        bc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
        end
        chk("calc_hold", {div_zero, hi, lo}, prev);
        start = 1'b1; op = MULTU; a = 32'd100; b = 32'd100;
        wait_result("multu_ignore_start", 5, bc, LAT, BUSY);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_queued_op", 65'(dn), 65'd0);

        // Reset in the middle of a divide.
        issue(DIVU, 32'd1000, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hilo", {div_zero, hi, lo}, 65'd0);
        chk("rst_mid_ctrl", {63'b0, busy, done}, 65'd0);
        void'(exp_q.pop_back());
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_discard", 65'(dn), 65'd0);
        chk("scoreboard_empty", 65'(exp_q.size()), 65'd0);

        // WIDTH=8 instance: done 9 edges after the start edge.
        start8 = 1'b1; op8 = MULTU; a8 = 8'hFF; b8 = 8'hFF;
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            start8 = 1'b0;
            n++;
            if (done8) seen = 1'b1;
        end
        chk("w8_done_seen", {64'b0, seen}, 65'd1);
        chk("w8_result", {49'b0, hi8, lo8}, 65'h0FE01);
        chk("w8_latency", 65'(n), 65'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
